// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared pipeline control types and widths
package pipeline_hazard_controller_pkg;
    localparam int ADDR_WIDTH = 4;
    typedef enum logic {NO_STALL, STALL_PIPELINE} stall_pipeline_sig;
    typedef enum logic {NO_FLUSH, FLUSH_PIPELINE} flush_pipeline_sig;
    typedef enum logic {NO_MEM_READ, MEM_READ} mem_read_signal;
    typedef enum logic {NO_REG_WRITE, REG_WRITE} reg_file_write_sig;
    typedef enum logic [1:0] {RUN = 2'd0, BRANCH_FLUSH = 2'd1} hazard_state_t;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) count_o <= '0;
        else if (en_i && !(&count_o)) count_o <= count_o + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall and taken-branch flush generation with perf counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dec_valid_i,
    input  logic [ADDR_WIDTH-1:0] dec_reg_1_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] dec_reg_2_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] dec_reg_3_source_addr_i,
    input  logic [2:0]            dec_src_used_i,
    input  logic                  ex_valid_i,
    input  mem_read_signal        ex_mem_read_en_i,
    input  reg_file_write_sig     ex_reg_file_write_en_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
    input  logic                  ex_branch_taken_i,
    output stall_pipeline_sig     stall_fetch_o,
    output stall_pipeline_sig     stall_decode_o,
    output flush_pipeline_sig     flush_fetch_decode_o,
    output flush_pipeline_sig     flush_decode_exec_o,
    output logic [1:0]            hazard_state_o,
    output logic [CNT_WIDTH-1:0]  stall_cycles_o,
    output logic [CNT_WIDTH-1:0]  flush_cycles_o
);
    localparam logic [3:0] RELOAD = 4'(BRANCH_FLUSH_CYCLES - 1);
    hazard_state_t r_state, w_next_state;
    logic [3:0] r_flush_cnt, w_next_cnt;
    logic [2:0] w_src_hit;
    logic w_load_use, w_branch;
    assign w_src_hit = dec_src_used_i & {dec_reg_3_source_addr_i == ex_reg_dest_addr_i,
                                         dec_reg_2_source_addr_i == ex_reg_dest_addr_i,
                                         dec_reg_1_source_addr_i == ex_reg_dest_addr_i};
    assign w_load_use = dec_valid_i && ex_valid_i && ex_mem_read_en_i == MEM_READ &&
                        ex_reg_file_write_en_i == REG_WRITE && |w_src_hit;
    assign w_branch = ex_valid_i && ex_branch_taken_i;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_cnt;
        end
    always_comb begin
        w_next_state         = r_state;
        w_next_cnt           = r_flush_cnt;
        stall_fetch_o        = NO_STALL;
        stall_decode_o       = NO_STALL;
        flush_fetch_decode_o = NO_FLUSH;
        flush_decode_exec_o  = NO_FLUSH;
        case (r_state)
            RUN: begin
                if (w_branch) begin
                    flush_fetch_decode_o = FLUSH_PIPELINE;
                    flush_decode_exec_o  = FLUSH_PIPELINE;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        w_next_state = BRANCH_FLUSH;
                        w_next_cnt   = RELOAD;
                    end
                end else if (w_load_use) begin
                    stall_fetch_o       = STALL_PIPELINE;
                    stall_decode_o      = STALL_PIPELINE;
                    flush_decode_exec_o = FLUSH_PIPELINE;
                end
            end
            BRANCH_FLUSH: begin
                flush_fetch_decode_o = FLUSH_PIPELINE;
                flush_decode_exec_o  = FLUSH_PIPELINE;
                if (w_branch) w_next_cnt = RELOAD;
                else if (r_flush_cnt <= 4'd1) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else w_next_cnt = r_flush_cnt - 4'd1;
            end
            default: begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        endcase
    end
    assign hazard_state_o = r_state;
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i(clk_i), .reset_i(reset_i),
        .en_i(stall_fetch_o == STALL_PIPELINE), .count_o(stall_cycles_o));
    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i(clk_i), .reset_i(reset_i),
        .en_i(flush_fetch_decode_o == FLUSH_PIPELINE), .count_o(flush_cycles_o));
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Generates the stall and flush controls consumed by the fetch/decode and decode/execute pipeline registers.
- Detects load-use hazards between the instruction in decode and the instruction in execute, and inserts one bubble.
- Detects taken branches resolved in execute and squashes younger instructions for a programmable number of cycles.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
ADDR_WIDTH, 4, register-file address width (package value)
BRANCH_FLUSH_CYCLES, 2, consecutive cycles both flush outputs stay asserted after a taken branch (legal range 1..15)
CNT_WIDTH, 16, width of the performance counters

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
dec_valid_i  in  1  decode-stage instruction is valid
dec_reg_1_source_addr_i  in  ADDR_WIDTH  decode source 1
dec_reg_2_source_addr_i  in  ADDR_WIDTH  decode source 2
dec_reg_3_source_addr_i  in  ADDR_WIDTH  decode source 3
dec_src_used_i  in  3  bit n set = source n+1 is read by the decode instruction
ex_valid_i  in  1  execute-stage is_valid
ex_mem_read_en_i  in  mem_read_signal  execute instruction is a load
ex_reg_file_write_en_i  in  reg_file_write_sig  execute instruction writes the register file
ex_reg_dest_addr_i  in  ADDR_WIDTH  execute destination
ex_branch_taken_i  in  1  execute resolved a taken branch this cycle
stall_fetch_o  out  stall_pipeline_sig  hold PC and the fetch/decode register
stall_decode_o  out  stall_pipeline_sig  hold the decode outputs
flush_fetch_decode_o  out  flush_pipeline_sig  invalidate the fetch/decode register
flush_decode_exec_o  out  flush_pipeline_sig  invalidate the decode/execute register
hazard_state_o  out  2  current FSM state encoding (debug)
stall_cycles_o  out  CNT_WIDTH  saturating count of load-use stall cycles
flush_cycles_o  out  CNT_WIDTH  saturating count of branch-flush cycles

Behaviour:
- Reset (asynchronous, active-high):
  - state = RUN, flush_cnt = 0, both counters = 0.
  - All stall outputs = NO_STALL, all flush outputs = NO_FLUSH.
- load_use, combinational:
  - Requires dec_valid_i, ex_valid_i, ex_mem_read_en_i==MEM_READ and ex_reg_file_write_en_i==REG_WRITE.
  - Also requires some n with dec_src_used_i[n] set and source n+1 address == ex_reg_dest_addr_i.
- branch, combinational: ex_valid_i && ex_branch_taken_i.
- FSM states: RUN, BRANCH_FLUSH. Outputs are Mealy, zero latency, valid in the same cycle as the inputs.
- RUN, branch true:
  - flush_fetch_decode_o = flush_decode_exec_o = FLUSH_PIPELINE; stalls = NO_STALL.
  - If BRANCH_FLUSH_CYCLES > 1, next state = BRANCH_FLUSH with flush_cnt = BRANCH_FLUSH_CYCLES-1.
  - Branch has priority over load_use; the load-use pair is squashed anyway.
- RUN, load_use true and branch false:
  - stall_fetch_o = stall_decode_o = STALL_PIPELINE.
  - flush_decode_exec_o = FLUSH_PIPELINE (bubble); flush_fetch_decode_o = NO_FLUSH.
  - Remain in RUN. On the next cycle execute holds the bubble (ex_valid_i=0), so the stall releases after exactly 1 cycle.
- RUN, neither condition: all outputs inactive.
- BRANCH_FLUSH:
  - Both flushes asserted; stalls NO_STALL; load_use ignored.
  - flush_cnt decrements each cycle; when it reaches 1 and no new branch, next state = RUN.
  - A valid taken branch while in BRANCH_FLUSH reloads flush_cnt = BRANCH_FLUSH_CYCLES-1 and stays in BRANCH_FLUSH.
- Counters:
  - stall_cycles_o increments in each cycle with stall_fetch_o active.
  - flush_cycles_o increments in each cycle with flush_fetch_decode_o active.
  - Both saturate at all-ones and never wrap.
- Address 0 is not special: a load to r0 followed by a read of r0 still stalls.
- dec_src_used_i bits that are clear never cause a hazard, even on an address match.

Decomposition:
- Shared package:
  - stall_pipeline_sig enum {NO_STALL, STALL_PIPELINE} (new).
  - Existing flush_pipeline_sig {NO_FLUSH, FLUSH_PIPELINE}, mem_read_signal, reg_file_write_sig, ADDR_WIDTH.
  - hazard_state_t enum {RUN, BRANCH_FLUSH}.
- One sub-module: sat_counter (parameterised width; enable, async reset, saturation). Instantiated twice.

Test Plan:
- Reset mid-flush: assert reset_i asynchronously while in BRANCH_FLUSH with flush_cnt=1 -> outputs inactive immediately, state RUN, counters 0.
- Load-use: ex = load to r3 (valid, MEM_READ, REG_WRITE); dec reads r3 via source 2, dec_src_used_i=3'b010 -> one cycle of stall_fetch/stall_decode/flush_decode_exec; next cycle (ex_valid_i=0) all inactive; stall_cycles_o=1.
- No false hazard: same as above but dec_src_used_i=3'b001 with source 1 = r5 -> no stall. Also ex_mem_read_en_i not MEM_READ with a matching address -> no stall.
- Branch with BRANCH_FLUSH_CYCLES=2: pulse ex_branch_taken_i with ex_valid_i=1 -> both flushes asserted for exactly 2 cycles, then RUN; flush_cycles_o=2.
- Simultaneous branch and load_use in the same cycle -> flushes asserted, stalls NO_STALL, stall_cycles_o unchanged.
- Saturation: preload by running CNT_WIDTH=4 for 20 stall cycles -> stall_cycles_o holds 15. Back-to-back branches 1 cycle apart -> flush window extends to 3 cycles total.
